sw_event_sequencer: RTL and testbench

Avalon-MM master that owns the 10-bit slide-switch PIO (data at word 0, irq_mask at word 2, edge_capture at word 3). It programs the PIO interrupt mask, services its irq by reading and clearing edge_capture and sampling the switch levels, and queues one event per service into a small FIFO. A downstream control-panel consumer drains the FIFO with a valid/ready handshake, so no CPU ISR is needed.

---
 rtl/sw_evt_pkg.sv | 13 +
 rtl/sw_event_sequencer_if.sv | 11 +
 rtl/sw_evt_fifo.sv | 39 +++
 rtl/sw_event_sequencer.sv | 109 ++++++++++
 tb/tb_sw_event_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sw_evt_pkg.sv
// sw_evt_pkg: shared state encoding, PIO word map and event-stamp widths for the switch event sequencer.
package sw_evt_pkg;
  typedef enum logic [2:0] {INIT, IDLE, RD_CAP, CLR, RD_DAT, PUSH} state_t;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int TS_W = 16;
`ifdef SW_EVT_TIMESTAMP_EN
  localparam int EVT_TS_W = TS_W;
`else
  localparam int EVT_TS_W = 0;
`endif
endpackage

// File: rtl/sw_event_sequencer_if.sv
// sw_event_sequencer_if: Avalon-MM slave-port signals of the slide-switch PIO plus its irq line.
interface sw_event_sequencer_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/sw_evt_fifo.sv
// sw_evt_fifo: synchronous FIFO with valid/ready drain side; push while full is accepted only alongside a pop.
module sw_evt_fifo #(
  parameter int W = 20,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [W-1:0] din,
  output logic full,
  output logic valid,
  input  logic ready,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic pop, do_push;
  assign pop = valid && ready;
  assign do_push = push && (!full || pop);
  assign full = count == (AW+1)'(DEPTH);
  assign valid = count != '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/sw_event_sequencer.sv
// sw_event_sequencer: services the switch PIO irq over Avalon-MM and queues {edges, levels} events.
// Optional SW_EVT_TIMESTAMP_EN appends a 16-bit cycle stamp sampled when the capture word is read.
module sw_event_sequencer
  import sw_evt_pkg::*;
#(
  parameter int N_SW = 10,
  parameter int DEPTH = 4,
  parameter logic [N_SW-1:0] INIT_MASK = 10'h3FF
) (
  input  logic clk,
  input  logic reset,
  sw_event_sequencer_if.master pio,
  input  logic [N_SW-1:0] cfg_mask,
  input  logic cfg_mask_wr,
  output logic evt_valid,
  input  logic evt_ready,
  output logic [2*N_SW+EVT_TS_W-1:0] evt_data,
  output logic busy
);
  localparam int EW = 2*N_SW + EVT_TS_W;
  state_t state;
  logic [N_SW-1:0] mask, edges;
  logic pending, full, push;
  logic [EW-1:0] push_data;
  logic unused_rd;
  assign unused_rd = ^pio.readdata[31:N_SW];
  assign busy = state != IDLE;
  assign push = state == PUSH && edges != '0;
  // Bus outputs are registered: each transition loads the bus cycle of the state being entered.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      pio.chipselect <= 1'b0;
      pio.write_n <= 1'b1;
      pio.address <= ADDR_DATA;
      pio.writedata <= '0;
      mask <= INIT_MASK;
      pending <= 1'b0;
      edges <= '0;
    end else begin
      pio.chipselect <= 1'b0;
      pio.write_n <= 1'b1;
      pio.address <= ADDR_DATA;
      pio.writedata <= '0;
      case (state)
        INIT:
          if (pio.chipselect) state <= IDLE;
          else begin
            pio.chipselect <= 1'b1;
            pio.write_n <= 1'b0;
            pio.address <= ADDR_MASK;
            pio.writedata <= 32'(mask);
            pending <= 1'b0;
          end
        IDLE:
          if (pending) state <= INIT;
          else if (pio.irq && !full) begin
            state <= RD_CAP;
            pio.chipselect <= 1'b1;
            pio.address <= ADDR_EDGE;
          end
        RD_CAP: begin
          state <= CLR;
          pio.chipselect <= 1'b1;
          pio.write_n <= 1'b0;
          pio.address <= ADDR_EDGE;
          pio.writedata <= 32'({N_SW{1'b1}});
        end
        CLR: begin
          edges <= pio.readdata[N_SW-1:0] & mask;
          state <= RD_DAT;
          pio.chipselect <= 1'b1;
          pio.address <= ADDR_DATA;
        end
        RD_DAT: state <= PUSH;
        PUSH: state <= IDLE;
        default: state <= INIT;
      endcase
      // A late pulse must survive the clear issued by INIT in the same cycle.
      if (cfg_mask_wr) begin
        mask <= cfg_mask;
        pending <= 1'b1;
      end
    end
`ifdef SW_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts, stamp;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts <= '0;
      stamp <= '0;
    end else begin
      ts <= ts + 1'b1;
      stamp <= state == CLR ? ts : stamp;
    end
  assign push_data = {edges, pio.readdata[N_SW-1:0], stamp};
`else
  assign push_data = {edges, pio.readdata[N_SW-1:0]};
`endif
  sw_evt_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(push_data),
    .full(full),
    .valid(evt_valid),
    .ready(evt_ready),
    .dout(evt_data)
  );
endmodule

// File: tb/tb_sw_event_sequencer.sv
// tb_sw_event_sequencer: directed bench with a PIO model and an event scoreboard checked every valid cycle.
module tb_sw_event_sequencer;
  import sw_evt_pkg::*;
  localparam int N_SW = 10;
  localparam int EW = 2*N_SW + EVT_TS_W;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N_SW-1:0] cfg_mask = '0;
  logic cfg_mask_wr = 1'b0;
  logic evt_valid, evt_ready = 1'b0, busy;
  logic [EW-1:0] evt_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sw_event_sequencer_if pio();
  sw_event_sequencer #(.N_SW(N_SW), .DEPTH(4), .INIT_MASK(10'h3FF)) dut (
    .clk(clk), .reset(reset), .pio(pio), .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data), .busy(busy)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // PIO model: registered readdata, OR-accumulating edge capture cleared by any write to word 3, never reset.
  logic [N_SW-1:0] cap = '0, sw = '0, pmask = '0, edge_in = '0;
  int n_wr = 0, n_rd = 0;
  logic [1:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  always @(posedge clk) begin
    if (pio.chipselect && !pio.write_n) begin
      n_wr <= n_wr + 1;
      wr_addr <= pio.address;
      wr_data <= pio.writedata;
      if (pio.address == 2'd2) pmask <= pio.writedata[N_SW-1:0];
    end
    if (pio.chipselect && pio.write_n) n_rd <= n_rd + 1;
    cap <= ((pio.chipselect && !pio.write_n && pio.address == 2'd3) ? '0 : cap) | edge_in;
    pio.readdata <= 32'(pio.address == 2'd0 ? sw : pio.address == 2'd2 ? pmask : pio.address == 2'd3 ? cap : '0);
  end
  assign pio.irq = |cap;
  // Scoreboard: one expected event per injected edge set whose masked value is nonzero.
  logic [2*N_SW-1:0] exp_q[$];
  logic [N_SW-1:0] exp_mask = 10'h3FF;
  int n_valid = 0;
  always begin
    @(negedge clk);
    #2;
    if (!reset && evt_valid) begin
      n_valid++;
      check("evt_data_vs_model", {1'b0, 20'(evt_data >> EVT_TS_W)},
            exp_q.size() != 0 ? {1'b0, exp_q[0]} : {1'b1, 20'h0});
      if (evt_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end
  task automatic inject(input logic [N_SW-1:0] e, input logic [N_SW-1:0] s, input bit model);
    sw = s;
    edge_in = e;
    if (model && (e & exp_mask) != '0) exp_q.push_back({e & exp_mask, s});
    @(negedge clk);
    edge_in = '0;
  endtask
  task automatic set_mask(input logic [N_SW-1:0] m);
    cfg_mask = m;
    cfg_mask_wr = 1'b1;
    @(negedge clk);
    cfg_mask_wr = 1'b0;
    exp_mask = m;
    repeat (6) @(negedge clk);
    check("mask_write_addr", wr_addr, 2);
    check("mask_write_data", wr_data, 32'(m));
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"}, pio.chipselect, 0);
    check({tag, "_write_n"}, pio.write_n, 1);
    check({tag, "_addr"}, pio.address, 0);
    check({tag, "_wdata"}, pio.writedata, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_valid"}, evt_valid, 0);
    check({tag, "_data"}, 64'(evt_data), 0);
  endtask
  logic [N_SW-1:0] ve[4] = '{10'h001, 10'h002, 10'h204, 10'h3FF};
  logic [N_SW-1:0] vs[4] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
  initial begin
    int k, w0, r0, v0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("init_write", {pio.chipselect, pio.write_n, pio.address}, {1'b1, 1'b0, 2'd2});
    check("init_wdata", pio.writedata, 32'h3FF);
    check("init_busy", busy, 1);
    @(negedge clk);
    check("idle_cs", pio.chipselect, 0);
    check("idle_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("init_wr_count", n_wr, 1);
    check("idle_rd_count", n_rd, 0);
    check("pio_mask", pmask, 10'h3FF);
    evt_ready = 1'b1;
    w0 = n_wr;
    r0 = n_rd;
    inject(10'h005, 10'h005, 1);
    k = 0;
    while (!evt_valid && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 2) check("clr_cycle_bus", {pio.chipselect, pio.write_n, pio.address}, {1'b1, 1'b0, 2'd3});
    end
    check("svc_latency", k, 5);
    check("svc_data", 20'(evt_data >> EVT_TS_W), 20'h01405);
    check("svc_clear_addr", wr_addr, 3);
    check("svc_wr_count", n_wr - w0, 1);
    check("svc_rd_count", n_rd - r0, 2);
    repeat (4) @(negedge clk);
    set_mask(10'h001);
    w0 = n_wr;
    v0 = n_valid;
    inject(10'h006, 10'h3A5, 1);
    repeat (10) @(negedge clk);
    check("masked_clear_issued", n_wr - w0, 1);
    check("masked_clear_addr", wr_addr, 3);
    check("masked_no_event", n_valid - v0, 0);
    check("masked_cap_cleared", cap, 0);
    set_mask(10'h3FF);
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inject(ve[i], vs[i], 1);
      repeat (8) @(negedge clk);
    end
    check("full_valid", evt_valid, 1);
    check("full_head", 20'(evt_data >> EVT_TS_W), 20'h007FF);
    r0 = n_rd;
    inject(10'h0F0, 10'h00F, 1);
    repeat (10) begin
      @(negedge clk);
      check("full_blocked_busy", busy, 0);
    end
    check("full_no_reads", n_rd - r0, 0);
    check("full_irq_held", pio.irq, 1);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    repeat (8) @(negedge clk);
    check("after_pop_serviced", n_rd - r0, 2);
    evt_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("drain_valid", evt_valid, 0);
    check("drain_queue", exp_q.size(), 0);
    evt_ready = 1'b0;
    inject(10'h040, 10'h001, 1);
    repeat (8) @(negedge clk);
    check("pre_reset_valid", evt_valid, 1);
    inject(10'h011, 10'h022, 0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_clr", {pio.chipselect, pio.write_n, pio.address}, {1'b1, 1'b0, 2'd3});
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    w0 = n_wr;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({10'h011, 10'h022});
    evt_ready = 1'b1;
    @(negedge clk);
    check("reinit_write", {pio.chipselect, pio.write_n, pio.address}, {1'b1, 1'b0, 2'd2});
    check("reinit_wdata", pio.writedata, 32'h3FF);
    repeat (12) @(negedge clk);
    check("reinit_queue", exp_q.size(), 0);
    check("reinit_wr_count", n_wr - w0, 2);
`ifdef SW_EVT_TIMESTAMP_EN
    begin
      logic [15:0] s1, s2;
      evt_ready = 1'b0;
      inject(10'h001, 10'h001, 1);
      repeat (19) @(negedge clk);
      inject(10'h002, 10'h002, 1);
      repeat (10) @(negedge clk);
      s1 = evt_data[15:0];
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      @(negedge clk);
      s2 = evt_data[15:0];
      check("stamp_delta", 16'(s2 - s1), 20);
      evt_ready = 1'b1;
      repeat (4) @(negedge clk);
    end
`endif
    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
